// File: rtl/spi_driver_pkg.sv
// Shared types and sizing helpers for the free-running SPI receive master.
package spi_driver_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      XFER,
      DONE
   } state_t;

   // Width for one counter that serves both the SCLK divider and the inter-frame gap.
   function automatic int cnt_width(input int clk_div, input int idle_cycles);
      int max_val;
      max_val = (clk_div > idle_cycles) ? clk_div : idle_cycles;
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/spi_driver_if.sv
// SPI pin bundle plus the received-byte output of spi_driver.
interface spi_driver_if;
   import spi_driver_pkg::*;

   logic                 miso;
   logic                 cs;
   logic                 sclk;
   logic [DATA_BITS-1:0] data_out;
   logic                 data_valid;

   modport master (input miso, output cs, sclk, data_out, data_valid);
   modport slave  (output miso, input cs, sclk, data_out, data_valid);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input bit; resets to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/spi_driver.sv
// Free-running mode-0 SPI master that reads one byte per frame from MISO, MSB first.
// Define SPI_DRIVER_MISO_SYNC_EN to pass MISO through a 2-flop synchronizer (needs CLK_DIV >= 3).
module spi_driver
   import spi_driver_pkg::*;
#(
   parameter int CLK_DIV     = 4,
   parameter int IDLE_CYCLES = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   spi_driver_if.master  bus
);

   localparam int CW = cnt_width(CLK_DIV, IDLE_CYCLES);
   localparam int BW = $clog2(DATA_BITS + 1);

   localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);
   localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS);

   state_t               r_state,      w_state_nxt;
   logic [CW-1:0]        r_cnt,        w_cnt_nxt;
   logic [BW-1:0]        r_bit_cnt,    w_bit_cnt_nxt;
   logic [DATA_BITS-1:0] r_shift,      w_shift_nxt;
   logic                 r_cs,         w_cs_nxt;
   logic                 r_sclk,       w_sclk_nxt;
   logic [DATA_BITS-1:0] r_data_out,   w_data_out_nxt;
   logic                 r_data_valid, w_data_valid_nxt;
   logic                 w_miso;

`ifdef SPI_DRIVER_MISO_SYNC_EN
   sync_2ff u_miso_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (bus.miso),
      .o_q   (w_miso)
   );
`else
   assign w_miso = bus.miso;
`endif

   // NOTE: every next-value is defaulted before the case so no path leaves one unassigned (no latches).
   always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = r_cnt + CW'(1);
      w_bit_cnt_nxt    = r_bit_cnt;
      w_shift_nxt      = r_shift;
      w_cs_nxt         = r_cs;
      w_sclk_nxt       = r_sclk;
      w_data_out_nxt   = r_data_out;
      w_data_valid_nxt = 1'b0;

      case (r_state)
         IDLE: begin
            w_cs_nxt   = 1'b1;
            w_sclk_nxt = 1'b0;
            if (r_cnt == IDLE_LAST) begin
               w_state_nxt   = SETUP;
               w_cnt_nxt     = '0;
               w_cs_nxt      = 1'b0;
               w_bit_cnt_nxt = '0;
            end
         end
         SETUP: begin
            if (r_cnt == DIV_LAST) begin
               w_state_nxt   = XFER;
               w_cnt_nxt     = '0;
               w_sclk_nxt    = 1'b1;
               w_shift_nxt   = {r_shift[DATA_BITS-2:0], w_miso};
               w_bit_cnt_nxt = BW'(1);
            end
         end
         XFER: begin
            if (r_cnt == DIV_LAST) begin
               w_cnt_nxt = '0;
               if (r_sclk) begin
                  w_sclk_nxt = 1'b0;
                  if (r_bit_cnt == BITS_LAST) begin
                     w_state_nxt = DONE;
                  end
               end else begin
                  // Sample on the same edge that raises SCLK, matching the SETUP exit.
                  w_sclk_nxt    = 1'b1;
                  w_shift_nxt   = {r_shift[DATA_BITS-2:0], w_miso};
                  w_bit_cnt_nxt = r_bit_cnt + BW'(1);
               end
            end
         end
         DONE: begin
            if (r_cnt == DIV_LAST) begin
               w_state_nxt      = IDLE;
               w_cnt_nxt        = '0;
               w_cs_nxt         = 1'b1;
               w_data_out_nxt   = r_shift;
               w_data_valid_nxt = 1'b1;
               w_bit_cnt_nxt    = '0;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_cs         <= 1'b1;
         r_sclk       <= 1'b0;
         r_data_out   <= '0;
         r_data_valid <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_bit_cnt    <= w_bit_cnt_nxt;
         r_shift      <= w_shift_nxt;
         r_cs         <= w_cs_nxt;
         r_sclk       <= w_sclk_nxt;
         r_data_out   <= w_data_out_nxt;
         r_data_valid <= w_data_valid_nxt;
      end
   end

   assign bus.cs         = r_cs;
   assign bus.sclk       = r_sclk;
   assign bus.data_out   = r_data_out;
   assign bus.data_valid = r_data_valid;

endmodule

// File: tb/tb_spi_driver.sv
// Directed bench for spi_driver at CLK_DIV=4, IDLE_CYCLES=16 with a falling-edge SPI slave model.
module tb_spi_driver;

   logic clk;
   logic rst_n;

   spi_driver_if bus ();

   spi_driver #(
      .CLK_DIV     (4),
      .IDLE_CYCLES (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   // Slave: presents bit 7 when CS falls, next bit on each SCLK falling edge.
   logic [7:0] slave_byte;
   logic [7:0] cur_byte;
   int         bit_idx;
   bit         in_frame;

   always @(bus.cs or negedge bus.sclk) begin
      if (bus.cs !== 1'b0) begin
         in_frame = 1'b0;
         bus.miso = 1'b0;
      end else if (!in_frame) begin
         in_frame = 1'b1;
         cur_byte = slave_byte;
         bit_idx  = 7;
         bus.miso = cur_byte[bit_idx];
      end else begin
         if (bit_idx > 0) bit_idx--;
         bus.miso = cur_byte[bit_idx];
      end
   end

   // Frame monitor: all figures are in system clock cycles.
   int   cyc = 0;
   int   fall_cyc = -1, period = 0, cs_low_len = 0, setup_len = 0;
   int   rise_cnt = 0, frame_rises = 0, sclk_rise_cyc = 0, sclk_fall_cyc = 0;
   int   hi_min = 1000, hi_max = 0, lo_min = 1000, lo_max = 0;
   int   unstable = 0, dbl_pulse = 0;
   logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_valid = 1'b0;
   logic [7:0] prev_data = 8'h00;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (prev_cs && !bus.cs) begin
         if (fall_cyc >= 0) period = cyc - fall_cyc;
         fall_cyc = cyc;
         rise_cnt = 0;
         hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
      end
      if (!prev_sclk && bus.sclk && !bus.cs) begin
         if (rise_cnt == 0) setup_len = cyc - fall_cyc;
         else begin
            if (cyc - sclk_fall_cyc < lo_min) lo_min = cyc - sclk_fall_cyc;
            if (cyc - sclk_fall_cyc > lo_max) lo_max = cyc - sclk_fall_cyc;
         end
         rise_cnt++;
         sclk_rise_cyc = cyc;
      end
      if (prev_sclk && !bus.sclk && !bus.cs) begin
         if (cyc - sclk_rise_cyc < hi_min) hi_min = cyc - sclk_rise_cyc;
         if (cyc - sclk_rise_cyc > hi_max) hi_max = cyc - sclk_rise_cyc;
         sclk_fall_cyc = cyc;
      end
      if (!prev_cs && bus.cs) begin
         cs_low_len  = cyc - fall_cyc;
         frame_rises = rise_cnt;
      end
      if (rst_n && bus.data_out !== prev_data && bus.data_valid !== 1'b1) unstable++;
      if (prev_valid && bus.data_valid) dbl_pulse++;
      prev_cs    = bus.cs;
      prev_sclk  = bus.sclk;
      prev_valid = bus.data_valid;
      prev_data  = bus.data_out;
   end

   task automatic wait_valid(output logic [7:0] d);
      bit got;
      got = 1'b0;
      d   = 'x;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (bus.data_valid === 1'b1) begin
            got = 1'b1;
            d   = bus.data_out;
         end
      end
   endtask

   task automatic check_frame(input string tag);
      check({tag, "_rises"},  frame_rises, 8);
      check({tag, "_cs_low"}, cs_low_len, 68);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      logic [7:0] vec [3];
      int n;
      vec = '{8'h00, 8'hFF, 8'h3C};

      slave_byte = 8'hA5;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_cs", bus.cs, 1);
      check("rst_sclk", bus.sclk, 0);
      check("rst_data_out", bus.data_out, 8'h00);
      check("rst_valid", bus.data_valid, 0);

      rst_n = 1'b1;
      n = 0;
      while (n < 100) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.cs === 1'b0) break;
      end
      check("cs_fall_after_rst", n, 16);

      wait_valid(d);
      #1;
      slave_byte = vec[0];
      check("a5_data", d, 8'hA5);
      check_frame("a5");
      check("a5_setup", setup_len, 4);
      check("a5_hi_min", hi_min, 4);
      check("a5_hi_max", hi_max, 4);
      check("a5_lo_min", lo_min, 4);
      check("a5_lo_max", lo_max, 4);
      @(negedge clk);
      check("a5_valid_width", bus.data_valid, 0);
      check("a5_held", bus.data_out, 8'hA5);

      for (int i = 0; i < 3; i++) begin
         wait_valid(d);
         #1;
         slave_byte = (i < 2) ? vec[i+1] : 8'hF0;
         check($sformatf("b2b%0d_data", i), d, vec[i]);
         check($sformatf("b2b%0d_period", i), period, 84);
         check_frame($sformatf("b2b%0d", i));
      end

      repeat (20) @(negedge clk);
      check("hold_mid_frame", bus.data_out, 8'h3C);

      n = 0;
      while (n < 200 && !(rise_cnt == 4 && bus.cs === 1'b0)) begin
         @(negedge clk);
         n++;
      end
      check("reach_bit4", rise_cnt, 4);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_cs", bus.cs, 1);
      check("midrst_sclk", bus.sclk, 0);
      check("midrst_data_out", bus.data_out, 8'h00);
      check("midrst_valid", bus.data_valid, 0);
      repeat (3) @(negedge clk);
      slave_byte = 8'h81;
      rst_n = 1'b1;

      wait_valid(d);
      #1;
      check("post_rst_data", d, 8'h81);
      check_frame("post_rst");

      check("data_stable", unstable, 0);
      check("single_pulse", dbl_pulse, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
